// File: rtl/key_rst_cond_if.sv
// Key/reset-request signal bundle for key_rst_cond: raw key in, conditioned
// reset request and status out. The slave modport is the conditioner's view.
interface key_rst_cond_if;
  logic       key_raw;
  logic       rst_req_n;
  logic       key_level;
  logic [7:0] press_cnt;
  logic       busy;

  modport slave (
    input  key_raw,
    output rst_req_n,
    output key_level,
    output press_cnt,
    output busy
  );

  modport master (
    output key_raw,
    input  rst_req_n,
    input  key_level,
    input  press_cnt,
    input  busy
  );
endinterface

// File: rtl/key_rst_cond.sv
// Push-button reset conditioner: synchronise and debounce a key, issue a fixed
// active-low reset-request pulse after power-on and on each accepted press.
// Optional periodic auto-reset is enabled by defining KEY_RST_COND_AUTO_RST_EN.
module key_rst_cond #(
  parameter logic [31:0] DEB_CYCLES   = 32'd1_000_000,
  parameter logic [7:0]  PULSE_CYCLES = 8'd16,
  parameter logic [31:0] AUTO_PERIOD  = 32'd200_000_000
) (
  input  logic           clk_in,
  input  logic           rst_in,
  key_rst_cond_if.slave  io
);

  typedef enum logic [1:0] {
    POR     = 2'd0,
    IDLE    = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [31:0] DEB_LAST   = DEB_CYCLES - 32'd1;
  localparam logic [7:0]  PULSE_LAST = PULSE_CYCLES - 8'd1;

  // Illegal parameter values stop elaboration rather than producing odd timing.
  if (DEB_CYCLES < 32'd2) begin : g_bad_deb
    $error("key_rst_cond: DEB_CYCLES must be at least 2");
  end
  if (PULSE_CYCLES == 8'd0) begin : g_bad_pulse
    $error("key_rst_cond: PULSE_CYCLES must be at least 1");
  end
  if (AUTO_PERIOD == 32'd0) begin : g_bad_auto
    $error("key_rst_cond: AUTO_PERIOD must be at least 1");
  end

  logic        sync1_r;
  logic        sync2_r;
  logic [31:0] deb_cnt_r;
  logic        key_level_r;
  logic        key_level_d_r;
  logic        press_s;
  logic        trig_s;
  state_t      state_r;
  state_t      state_nxt;
  logic [7:0]  pulse_cnt_r;
  logic [7:0]  press_cnt_r;
  logic        rst_req_n_s;
  logic        busy_s;
  logic        rst_req_n_r;
  logic        busy_r;

  // Two-flop synchroniser for the asynchronous key; idles at released (1).
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= io.key_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: the level follows the key only after DEB_CYCLES unbroken differing cycles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      deb_cnt_r   <= 32'd0;
      key_level_r <= 1'b1;
    end else if (sync2_r == key_level_r) begin
      deb_cnt_r   <= 32'd0;
      key_level_r <= key_level_r;
    end else if (deb_cnt_r == DEB_LAST) begin
      deb_cnt_r   <= 32'd0;
      key_level_r <= sync2_r;
    end else begin
      deb_cnt_r   <= deb_cnt_r + 32'd1;
      key_level_r <= key_level_r;
    end
  end

  // Delayed level for falling-edge (press) detection one cycle after the change.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      key_level_d_r <= 1'b1;
    end else begin
      key_level_d_r <= key_level_r;
    end
  end

  assign press_s = key_level_d_r & ~key_level_r;

`ifdef KEY_RST_COND_AUTO_RST_EN
  localparam logic [31:0] AUTO_LAST = AUTO_PERIOD - 32'd1;

  logic [31:0] auto_cnt_r;
  logic        auto_exp_s;

  assign auto_exp_s = (state_r == IDLE) && (auto_cnt_r == AUTO_LAST);
  assign trig_s     = press_s | auto_exp_s;

  // Auto-reset interval counter: runs only in IDLE, restarts on every pulse entry.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      auto_cnt_r <= 32'd0;
    end else if ((state_nxt == PULSE) && (state_r != PULSE)) begin
      auto_cnt_r <= 32'd0;
    end else if (state_r == IDLE) begin
      auto_cnt_r <= auto_cnt_r + 32'd1;
    end else begin
      auto_cnt_r <= auto_cnt_r;
    end
  end
`else
  assign trig_s = press_s;
`endif

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= POR;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic; a held key parks in HOLDOFF so it yields one pulse only.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      POR: begin
        state_nxt = PULSE;
      end
      IDLE: begin
        if (trig_s) begin
          state_nxt = PULSE;
        end else begin
          state_nxt = IDLE;
        end
      end
      PULSE: begin
        if (pulse_cnt_r == PULSE_LAST) begin
          if (!key_level_r) begin
            state_nxt = HOLDOFF;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = PULSE;
        end
      end
      HOLDOFF: begin
        if (key_level_r) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = HOLDOFF;
        end
      end
      default: begin
        state_nxt = POR;
      end
    endcase
  end

  // FSM output decode from the next state so the registered outputs track the state.
  always_comb begin
    rst_req_n_s = 1'b0;
    busy_s      = 1'b1;
    case (state_nxt)
      POR: begin
        rst_req_n_s = 1'b0;
        busy_s      = 1'b1;
      end
      IDLE: begin
        rst_req_n_s = 1'b1;
        busy_s      = 1'b0;
      end
      PULSE: begin
        rst_req_n_s = 1'b0;
        busy_s      = 1'b1;
      end
      HOLDOFF: begin
        rst_req_n_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: begin
        rst_req_n_s = 1'b0;
        busy_s      = 1'b1;
      end
    endcase
  end

  // Output flops keep rst_req_n and busy glitch-free.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rst_req_n_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      rst_req_n_r <= rst_req_n_s;
      busy_r      <= busy_s;
    end
  end

  // Pulse-width counter: counts PULSE cycles, zero outside a pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pulse_cnt_r <= 8'd0;
    end else if ((state_r == PULSE) && (state_nxt == PULSE)) begin
      pulse_cnt_r <= pulse_cnt_r + 8'd1;
    end else begin
      pulse_cnt_r <= 8'd0;
    end
  end

  // Accepted-press counter; presses outside IDLE are ignored, wraps silently.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      press_cnt_r <= 8'd0;
    end else if ((state_r == IDLE) && press_s) begin
      press_cnt_r <= press_cnt_r + 8'd1;
    end else begin
      press_cnt_r <= press_cnt_r;
    end
  end

  assign io.rst_req_n = rst_req_n_r;
  assign io.busy      = busy_r;
  assign io.key_level = key_level_r;
  assign io.press_cnt = press_cnt_r;

endmodule

// File: tb/tb_key_rst_cond.sv
// Scoreboard bench for key_rst_cond: stimulus pushes the expected reset-request
// pulses, a monitor compares each completed pulse against the queue.
module tb_key_rst_cond;

  localparam logic [31:0] DEB  = 32'd8;
  localparam logic [7:0]  PUL  = 8'd4;
  localparam logic [31:0] AUTO = 32'd50;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  key_rst_cond_if bus ();

  key_rst_cond #(
    .DEB_CYCLES  (DEB),
    .PULSE_CYCLES(PUL),
    .AUTO_PERIOD (AUTO)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .io    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int width;
    int cnt;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   n_pulse = 0;
  int   cyc     = 0;
  int   low_len = 0;
  int   last_rise = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: measure every low stretch of rst_req_n and score it when it ends.
  always @(negedge clk_in) begin
    exp_t e;
    cyc++;
    if (!rst_in) begin
      low_len  = 0;
      prev_req = 1'b0;
    end else begin
      if (bus.rst_req_n === 1'b0) begin
        low_len++;
      end else if (prev_req === 1'b0) begin
        n_pulse++;
        if (exp_q.size() == 0) begin
          check("pulse_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("pulse_width", low_len, e.width);
          check("pulse_press_cnt", bus.press_cnt, e.cnt);
          if (e.gap > 0) check("pulse_gap", cyc - last_rise, e.gap);
        end
        last_rise = cyc;
        low_len   = 0;
      end
      prev_req = bus.rst_req_n;
    end
  end

  task automatic release_reset();
    @(negedge clk_in);
    #1 rst_in = 1'b1;
  endtask

  initial begin
    int k;
    int base;
    logic dropped;
    bus.key_raw = 1'b1;
    #1 rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_rst_req_n", bus.rst_req_n, 0);
    check("reset_key_level", bus.key_level, 1);
    check("reset_press_cnt", bus.press_cnt, 0);
    check("reset_busy", bus.busy, 1);
    exp_q.push_back('{4, 0, 0});
    release_reset();

`ifdef KEY_RST_COND_AUTO_RST_EN
    for (int i = 0; i < 3; i++) exp_q.push_back('{4, 0, 54});
    repeat (180) @(negedge clk_in);
    check("auto_pulses_seen", exp_q.size(), 0);
    check("auto_press_cnt", bus.press_cnt, 0);
`else
    repeat (10) @(negedge clk_in);
    check("por_busy", bus.busy, 0);
    check("por_rst_req_n", bus.rst_req_n, 1);
    check("por_press_cnt", bus.press_cnt, 0);

    // Bounce shorter than the debounce window must never move key_level.
    dropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1 bus.key_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) begin
        @(negedge clk_in);
        if (bus.key_level !== 1'b1) dropped = 1'b1;
      end
    end
    #1 bus.key_raw = 1'b1;
    repeat (20) begin
      @(negedge clk_in);
      if (bus.key_level !== 1'b1) dropped = 1'b1;
    end
    check("bounce_level_dropped", dropped, 0);
    check("bounce_press_cnt", bus.press_cnt, 0);
    check("bounce_pulse_count", n_pulse, 1);

    // Held press: 2 sync + 8 debounce, pulse one cycle later, HOLDOFF until release.
    exp_q.push_back('{4, 1, 0});
    #1 bus.key_raw = 1'b0;
    k = 0;
    while (bus.key_level !== 1'b0 && k < 60) begin @(negedge clk_in); k++; end
    check("press_deb_latency", k, 10);
    while (bus.rst_req_n !== 1'b0 && k < 60) begin @(negedge clk_in); k++; end
    check("press_pulse_latency", k, 11);
    repeat (89) @(negedge clk_in);
    check("hold_busy", bus.busy, 1);
    check("hold_rst_req_n", bus.rst_req_n, 1);
    check("hold_press_cnt", bus.press_cnt, 1);
    #1 bus.key_raw = 1'b1;
    k = 0;
    while (bus.key_level !== 1'b1 && k < 60) begin @(negedge clk_in); k++; end
    check("release_deb_latency", k, 10);
    check("release_busy_still", bus.busy, 1);
    @(negedge clk_in);
    check("release_busy_clear", bus.busy, 0);

    // 256 clean presses from a fresh reset: counter wraps back to 0.
    #1 rst_in = 1'b0;
    exp_q.push_back('{4, 0, 0});
    repeat (2) @(negedge clk_in);
    release_reset();
    repeat (10) @(negedge clk_in);
    base = n_pulse;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{4, (i + 1) % 256, 0});
      #1 bus.key_raw = 1'b0;
      repeat (20) @(negedge clk_in);
      #1 bus.key_raw = 1'b1;
      repeat (20) @(negedge clk_in);
    end
    check("wrap_press_cnt", bus.press_cnt, 0);
    check("wrap_pulse_count", n_pulse - base, 256);

    // Reset in the second PULSE cycle aborts the pulse and restarts POR.
    #1 bus.key_raw = 1'b0;
    k = 0;
    while (bus.rst_req_n !== 1'b0 && k < 60) begin @(negedge clk_in); k++; end
    check("abort_pulse_latency", k, 11);
    @(negedge clk_in);
    #1 rst_in = 1'b0;
    exp_q.push_back('{4, 0, 0});
    #1;
    check("abort_rst_req_n", bus.rst_req_n, 0);
    check("abort_key_level", bus.key_level, 1);
    check("abort_press_cnt", bus.press_cnt, 0);
    check("abort_busy", bus.busy, 1);
    bus.key_raw = 1'b1;
    repeat (3) @(negedge clk_in);
    release_reset();
    repeat (12) @(negedge clk_in);
    check("abort_post_busy", bus.busy, 0);
    check("abort_post_rst_req_n", bus.rst_req_n, 1);
    check("all_pulses_seen", exp_q.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_rst_cond.md
KEY_RST_COND -- requirements
Module: key_rst_cond

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1_000_000: debounce stable-time in clk_in cycles (10 ms at 100 MHz), legal range 2..2^32-1.
REQ-002 SHALL have parameter PULSE_CYCLES, default 16: width of the reset-request pulse in clk_in cycles, legal range 1..255.
REQ-003 SHALL have parameter AUTO_PERIOD, default 200_000_000: auto-reset interval in clk_in cycles, used only with AUTO_RST_EN.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port key_raw, input, 1 bit: raw push-button, asynchronous and bouncing; 0 = pressed.
REQ-007 SHALL have port rst_req_n, output, 1 bit: active-low reset request that drives the downstream reset-pulse stage's rst_in.
REQ-008 SHALL have port key_level, output, 1 bit: debounced key level; 0 = pressed.
REQ-009 SHALL have port press_cnt, output, 8 bits: count of accepted key presses.
REQ-010 SHALL have port busy, output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-011 SHALL synchronize key_raw through a 2-flop synchronizer before any other use.
REQ-012 SHALL update key_level only after the synchronized key has differed from key_level for DEB_CYCLES consecutive cycles; any cycle where they match SHALL clear the debounce counter.
REQ-013 SHALL define a press event as a key_level transition 1->0, detected in the cycle after the transition.
REQ-014 SHALL implement an FSM with states POR, IDLE, PULSE and HOLDOFF.
REQ-015 SHALL leave POR on the first clock after rst_in deasserts, drive rst_req_n=0 for exactly PULSE_CYCLES cycles, then enter IDLE.
REQ-016 SHALL, on a press event in IDLE, enter PULSE on the next cycle and increment press_cnt once.
REQ-017 SHALL drive rst_req_n=0 for exactly PULSE_CYCLES cycles while in PULSE.
REQ-018 SHALL, at the end of PULSE, go to HOLDOFF if key_level=0, otherwise go to IDLE.
REQ-019 SHALL leave HOLDOFF for IDLE only when key_level=1, so a held key produces exactly one pulse.
REQ-020 SHALL ignore press events in POR, PULSE and HOLDOFF, with no press_cnt change.
REQ-021 SHALL wrap press_cnt from 255 to 0 with no flag.
REQ-022 SHALL drive rst_req_n=1 at all times in IDLE and HOLDOFF.
REQ-023 SHALL produce rst_req_n, busy and key_level directly from flops, free of glitches.

Reset
REQ-024 SHALL, while rst_in=0, immediately hold rst_req_n=0, key_level=1, press_cnt=0, busy=1, FSM=POR, all counters=0 and both synchronizer flops=1.
REQ-025 SHALL, on rst_in asserting mid-PULSE or mid-HOLDOFF, abort the operation and restart the full POR sequence after release.

Configuration
REQ-026 SHALL, with macro KEY_RST_COND_AUTO_RST_EN defined, include a 32-bit auto counter that increments only in IDLE.
REQ-027 SHALL, with KEY_RST_COND_AUTO_RST_EN defined and the auto counter reaching AUTO_PERIOD-1, clear the counter and enter PULSE exactly as for a press, without incrementing press_cnt.
REQ-028 SHALL clear the auto counter on every entry to PULSE.
REQ-029 SHALL, when a press event and auto expiry coincide, produce one pulse and increment press_cnt by 1.
REQ-030 SHALL, with KEY_RST_COND_AUTO_RST_EN undefined, contain no auto counter logic, and rst_req_n SHALL assert only after POR or a key press.

Verification
REQ-031 SHALL cover, with DEB_CYCLES=8 and PULSE_CYCLES=4: rst_in released -> rst_req_n low 4 cycles after release, then high; busy=0; press_cnt=0.
REQ-032 SHALL cover: key_raw toggled every 3 cycles for 60 cycles, then left at 1 -> key_level stays 1, no pulse.
REQ-033 SHALL cover: key_raw=0 held 100 cycles -> key_level falls 10 cycles after the edge (2 sync + 8 debounce); one 4-cycle rst_req_n pulse; press_cnt=1; busy=1 until release is debounced.
REQ-034 SHALL cover: 256 clean presses -> press_cnt=0 and 256 pulses.
REQ-035 SHALL cover: rst_in pulsed low in the 2nd PULSE cycle -> outputs take reset values at once; a fresh 4-cycle POR pulse follows release.
REQ-036 SHALL cover, with KEY_RST_COND_AUTO_RST_EN and AUTO_PERIOD=50, key idle: rst_req_n pulses every 50+4 cycles; press_cnt stays 0.
